mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits between the instruction-fetch unit (IFU), the load/store unit (LSU) and the single byte-addressed, 32-bit, little-endian Mem block.
- Sequences every Mem access:
  - drives the op/rw/addr/data_w strobes;
  - captures data_r;
  - arbitrates round-robin between the two requesters;
  - performs sub-word stores as read-modify-write, because Mem always writes all 4 bytes;
  - extracts and sign/zero-extends sub-word loads.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width; fixed at 4 byte lanes.
- MEM_SIZE, 1024, Mem size in bytes; used for the range check.

Ports:
- sys_clk  in  1  clock; all state updates on posedge.
- sys_rst  in  1  synchronous, active-high reset.
- ifu_req  in  1  fetch request; held until ifu_ack.
- ifu_addr  in  ADDR_WIDTH  fetch byte address.
- ifu_ack  out  1  one-cycle completion pulse.
- ifu_rdata  out  DATA_WIDTH  fetched word; valid while ifu_ack=1.
- ifu_err  out  1  misaligned or out-of-range fetch; qualified by ifu_ack.
- lsu_req  in  1  load/store request; held, with all lsu_* fields stable, until lsu_ack.
- lsu_we  in  1  0=load, 1=store.
- lsu_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and flags err.
- lsu_sext  in  1  loads only: 1=sign-extend, 0=zero-extend.
- lsu_addr  in  ADDR_WIDTH  byte address.
- lsu_wdata  in  DATA_WIDTH  store data, right-justified.
- lsu_ack  out  1  one-cycle completion pulse.
- lsu_rdata  out  DATA_WIDTH  extended load data; valid while lsu_ack=1.
- lsu_err  out  1  misaligned, out-of-range or illegal size; qualified by lsu_ack.
- mem_op  out  1  to Mem op.
- mem_rw  out  1  to Mem rw.
- mem_addr  out  ADDR_WIDTH  to Mem addr; always word-aligned.
- mem_data_w  out  DATA_WIDTH  to Mem data_w.
- mem_data_r  in  DATA_WIDTH  from Mem data_r.

Behaviour:
- Reset:
  - All mem_* outputs 0; all ack/err/rdata outputs 0.
  - state=IDLE; last_grant=IFU.
  - A reset mid-operation aborts immediately: mem_op is 0 in the next cycle, no write is issued, no ack is given. The requester must reissue.
- All outputs are registered. Mem acts on the negedge inside the cycle where mem_op=1, so mem_data_r is stable at the following posedge.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - Samples the requests.
  - If both are pending, grant the one not equal to last_grant, so the first contention after reset goes to the LSU.
  - Update last_grant on every grant.
  - Errors: misaligned (half with addr[0]=1; word with addr[1:0]!=0), size=3, or addr+nbytes > MEM_SIZE → go to RESP with err=1 and no Mem access.
  - Otherwise, drive mem_op=1 and mem_addr={addr[ADDR_WIDTH-1:2],2'b00}, then:
    - fetch or load: mem_rw=0 → RD;
    - word store: mem_rw=1, mem_data_w=wdata → WR;
    - byte/half store: mem_rw=0 → RMW_RD.
- RD: capture mem_data_r into the response, deassert mem_op → RESP.
  - Fetch: the word as read.
  - Load: lane selected by addr[1:0], then extended per lsu_sext.
- RMW_RD:
  - Merge wdata[7:0] or wdata[15:0] into the captured word at byte lane addr[1:0].
  - Drive mem_rw=1 with the merged word, mem_op=1 → WR.
- WR: deassert mem_op → RESP.
- RESP:
  - ack=1 for exactly one cycle to the granted requester → IDLE.
  - A req still high in RESP is ignored. If it is still high in the following IDLE cycle, it is a new request.
- Latency from the IDLE sampling cycle N: ack in cycle N+2 for read, fetch and word store; N+3 for sub-word store; N+1 for an error.
- mem_op is never high for two requesters in the same cycle. While a transaction is in flight, the other requester waits with no timeout.

Test Plan:
- Word fetch: mem[0..3]=93 05 50 00, ifu_req with addr=0 → ifu_ack 2 cycles later, ifu_rdata=0x00500593, err=0.
- Simultaneous ifu_req (addr 4) and lsu_req (load word, addr 8) right after reset → LSU acked first; IFU acked next, 3 cycles after the LSU ack.
- Byte store 0xAB at addr 0x11 over word 0x11223344 at 0x10 → exactly one read then one write; Mem word becomes 0x1122AB44; lsu_ack 3 cycles after sampling.
- Signed half load at 0x12 of word 0x80FF0000 → lsu_rdata=0xFFFF80FF; with lsu_sext=0 → 0x000080FF.
- Word load at addr 0x6, and word load at addr 1022 → lsu_err=1 with ack the next cycle; mem_op never asserted.
- Reset asserted during RMW_RD of a half store → no write occurs (memory unchanged), no ack; all outputs 0 on the cycle after reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin IFU/LSU arbiter sequencing a single 32-bit word Mem.
// Sub-word stores become read-modify-write; sub-word loads are lane-extracted and extended.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  ifu_req,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_ack,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic                  ifu_err,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [1:0]            lsu_size,
    input  logic                  lsu_sext,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_ack,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_err,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_last_lsu;
    logic                  r_cur_lsu;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_sext;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_any;
    logic                  w_pick_lsu;
    logic                  w_we;
    logic                  w_misalign;
    logic                  w_oor;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [1:0]            w_size;
    logic [2:0]            w_nbytes;
    logic [ADDR_WIDTH:0]   w_end;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_wshift;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [3:0]            w_be;

    // On contention the requester that did not win last time gets the grant.
    assign w_any      = ifu_req | lsu_req;
    assign w_pick_lsu = lsu_req & (~ifu_req | ~r_last_lsu);
    assign w_addr     = w_pick_lsu ? lsu_addr : ifu_addr;
    assign w_size     = w_pick_lsu ? lsu_size : 2'd2;
    assign w_we       = w_pick_lsu & lsu_we;

    always_comb begin
        w_nbytes = 3'd0;
        case (w_size)
            2'd0:    w_nbytes = 3'd1;
            2'd1:    w_nbytes = 3'd2;
            2'd2:    w_nbytes = 3'd4;
            default: w_nbytes = 3'd0;
        endcase
    end

    assign w_misalign = (w_size == 2'd1 && w_addr[0]) || (w_size == 2'd2 && w_addr[1:0] != 2'b00);
    assign w_end      = {1'b0, w_addr} + {{(ADDR_WIDTH-2){1'b0}}, w_nbytes};
    assign w_oor      = w_end > (ADDR_WIDTH+1)'(MEM_SIZE);
    assign w_err      = (w_size == 2'd3) | w_misalign | w_oor;

    assign w_shifted = mem_data_r >> {r_lane, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'd0:    w_load = {{(DATA_WIDTH-8){r_sext & w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_load = {{(DATA_WIDTH-16){r_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // Store data is right-justified; move it up to its byte lane before merging.
    assign w_be     = ((r_size == 2'd0) ? 4'b0001 : 4'b0011) << r_lane;
    assign w_wshift = r_wdata << {r_lane, 3'b000};

    always_comb begin
        w_merged = mem_data_r;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_wshift[8*i +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_last_lsu <= 1'b0;
            r_cur_lsu  <= 1'b0;
            r_lane     <= 2'd0;
            r_size     <= 2'd0;
            r_sext     <= 1'b0;
            r_wdata    <= '0;
            ifu_ack    <= 1'b0;
            ifu_err    <= 1'b0;
            ifu_rdata  <= '0;
            lsu_ack    <= 1'b0;
            lsu_err    <= 1'b0;
            lsu_rdata  <= '0;
            mem_op     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_data_w <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cur_lsu  <= w_pick_lsu;
                        r_last_lsu <= w_pick_lsu;
                        r_lane     <= w_addr[1:0];
                        r_size     <= w_size;
                        r_sext     <= w_pick_lsu & lsu_sext;
                        r_wdata    <= lsu_wdata;
                        if (w_err) begin
                            r_state <= S_RESP;
                            if (w_pick_lsu) begin
                                lsu_ack   <= 1'b1;
                                lsu_err   <= 1'b1;
                                lsu_rdata <= '0;
                            end else begin
                                ifu_ack   <= 1'b1;
                                ifu_err   <= 1'b1;
                                ifu_rdata <= '0;
                            end
                        end else begin
                            mem_op   <= 1'b1;
                            mem_addr <= {w_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (!w_we) begin
                                mem_rw  <= 1'b0;
                                r_state <= S_RD;
                            end else if (w_size == 2'd2) begin
                                mem_rw     <= 1'b1;
                                mem_data_w <= lsu_wdata;
                                r_state    <= S_WR;
                            end else begin
                                mem_rw  <= 1'b0;
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    mem_op  <= 1'b0;
                    r_state <= S_RESP;
                    if (r_cur_lsu) begin
                        lsu_ack   <= 1'b1;
                        lsu_err   <= 1'b0;
                        lsu_rdata <= w_load;
                    end else begin
                        ifu_ack   <= 1'b1;
                        ifu_err   <= 1'b0;
                        ifu_rdata <= mem_data_r;
                    end
                end
                S_RMW_RD: begin
                    mem_rw     <= 1'b1;
                    mem_data_w <= w_merged;
                    r_state    <= S_WR;
                end
                S_WR: begin
                    mem_op  <= 1'b0;
                    mem_rw  <= 1'b0;
                    lsu_ack <= 1'b1;
                    lsu_err <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    ifu_ack <= 1'b0;
                    ifu_err <= 1'b0;
                    lsu_ack <= 1'b0;
                    lsu_err <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    localparam int MS = 1024;

    logic        sys_clk    = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        ifu_req    = 1'b0;
    logic [31:0] ifu_addr   = '0;
    logic        ifu_ack;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_req    = 1'b0;
    logic        lsu_we     = 1'b0;
    logic [1:0]  lsu_size   = '0;
    logic        lsu_sext   = 1'b0;
    logic [31:0] lsu_addr   = '0;
    logic [31:0] lsu_wdata  = '0;
    logic        lsu_ack;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_op;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r = '0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MS)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_sext(lsu_sext),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_op(mem_op), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Mem: acts on the negedge of any cycle with mem_op=1.
    logic [7:0] phys [MS] = '{default: 8'h00};
    int rd_cnt = 0;
    int wr_cnt = 0;
    always @(negedge sys_clk) begin
        if (mem_op === 1'b1) begin
            chk("mem_addr_legal", 32'(mem_addr[1:0] == 2'b00 && mem_addr < MS), 32'd1);
            if (mem_addr[1:0] == 2'b00 && mem_addr < MS) begin
                if (mem_rw) begin
                    for (int i = 0; i < 4; i++) phys[mem_addr + i] = mem_data_w[8*i +: 8];
                    wr_cnt++;
                end else begin
                    mem_data_r <= {phys[mem_addr + 3], phys[mem_addr + 2], phys[mem_addr + 1], phys[mem_addr]};
                    rd_cnt++;
                end
            end
        end
    end

    function automatic logic [31:0] peek(input int a);
        return {phys[a + 3], phys[a + 2], phys[a + 1], phys[a]};
    endfunction

    // Transaction model: byte-array memory, latency table, round-robin on contention.
    logic [7:0]  refm [MS] = '{default: 8'h00};
    bit          exp_valid = 0, exp_lsu = 0, exp_err = 0, exp_store = 0, last_lsu = 0;
    int          exp_cyc = 0, exp_acc = 0, free_cyc = 0, acc_total = 0, st_n = 0;
    longint      st_addr = 0;
    logic [31:0] exp_data = '0, st_data = '0;

    always @(negedge sys_clk) begin : model
        bit          due, g_lsu, st;
        longint      a;
        int          n, lat;
        logic [63:0] v;
        due = exp_valid && exp_cyc == cyc;
        chk("ifu_ack", 32'(ifu_ack), 32'(due && !exp_lsu));
        chk("lsu_ack", 32'(lsu_ack), 32'(due && exp_lsu));
        if (due && !exp_lsu && ifu_ack === 1'b1) begin
            chk("ifu_err", 32'(ifu_err), 32'(exp_err));
            if (!exp_err) chk("ifu_rdata", ifu_rdata, exp_data);
        end
        if (due && exp_lsu && lsu_ack === 1'b1) begin
            chk("lsu_err", 32'(lsu_err), 32'(exp_err));
            if (!exp_err && !exp_store) chk("lsu_rdata", lsu_rdata, exp_data);
        end
        if (due) begin
            if (exp_store && !exp_err)
                for (int i = 0; i < st_n; i++) refm[st_addr + i] = st_data[8*i +: 8];
            acc_total += exp_acc;
            exp_valid = 0;
        end
        if (sys_rst) begin
            exp_valid = 0;
            free_cyc  = cyc + 1;
            last_lsu  = 0;
        end else if (cyc >= free_cyc && (ifu_req || lsu_req)) begin
            g_lsu    = lsu_req && (!ifu_req || !last_lsu);
            last_lsu = g_lsu;
            a  = g_lsu ? longint'(lsu_addr) : longint'(ifu_addr);
            n  = !g_lsu ? 4 : (lsu_size == 2'd0) ? 1 : (lsu_size == 2'd1) ? 2 : (lsu_size == 2'd2) ? 4 : 0;
            st = g_lsu && lsu_we;
            exp_err = (n == 0) || (a % n != 0) || (a + n > MS);
            lat     = exp_err ? 1 : (st && n < 4) ? 3 : 2;
            exp_acc = exp_err ? 0 : (st && n < 4) ? 2 : 1;
            v = '0;
            if (!exp_err && !st) begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = refm[a + i];
                if (g_lsu && lsu_sext && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            end
            exp_data  = v[31:0];
            exp_lsu   = g_lsu;
            exp_store = st;
            st_addr   = a;
            st_n      = n;
            st_data   = lsu_wdata;
            exp_cyc   = cyc + lat;
            free_cyc  = cyc + lat + 1;
            exp_valid = 1;
        end
    end

    int          ifu_acks = 0, lsu_acks = 0, ifu_ack_cyc = 0, lsu_ack_cyc = 0;
    logic [31:0] ifu_last_rdata = '0, lsu_last_rdata = '0;
    logic        ifu_last_err = 1'b0, lsu_last_err = 1'b0;
    always @(negedge sys_clk) begin
        if (ifu_ack === 1'b1) begin
            ifu_acks++;
            ifu_ack_cyc    = cyc;
            ifu_last_rdata = ifu_rdata;
            ifu_last_err   = ifu_err;
        end
        if (lsu_ack === 1'b1) begin
            lsu_acks++;
            lsu_ack_cyc    = cyc;
            lsu_last_rdata = lsu_rdata;
            lsu_last_err   = lsu_err;
        end
    end

    int ifu_done = 0;
    int lsu_done = 0;

    function automatic logic [31:0] rand_addr(input int n);
        int a;
        a = $urandom_range(0, MS + 7);
        if ($urandom_range(0, 9) < 8) a = a - (a % n);
        return 32'(a);
    endfunction

    task automatic step(input bit rnd);
        int r;
        @(posedge sys_clk); #1;
        if (ifu_req && ifu_acks != ifu_done) begin
            ifu_req  = 1'b0;
            ifu_done = ifu_acks;
        end else if (!ifu_req && rnd && $urandom_range(0, 2) == 0) begin
            ifu_addr = rand_addr(4);
            ifu_req  = 1'b1;
        end
        if (lsu_req && lsu_acks != lsu_done) begin
            lsu_req  = 1'b0;
            lsu_done = lsu_acks;
        end else if (!lsu_req && rnd && $urandom_range(0, 2) == 0) begin
            r         = $urandom_range(0, 15);
            lsu_size  = (r == 0) ? 2'd3 : 2'(r % 3);
            lsu_we    = 1'($urandom_range(0, 1));
            lsu_sext  = 1'($urandom_range(0, 1));
            lsu_wdata = $urandom;
            lsu_addr  = rand_addr((r == 0) ? 1 : (1 << (r % 3)));
            lsu_req   = 1'b1;
        end
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while ((ifu_req || lsu_req) && k < bound) begin
            step(0);
            k++;
        end
        chk("drain_timeout", 32'(ifu_req || lsu_req), 32'd0);
    endtask

    task automatic issue_lsu(input bit we, input logic [1:0] sz, input bit sx,
                             input logic [31:0] a, input logic [31:0] wd, output int n0);
        @(posedge sys_clk); #1;
        lsu_we = we; lsu_size = sz; lsu_sext = sx; lsu_addr = a; lsu_wdata = wd;
        lsu_req = 1'b1;
        n0 = cyc;
    endtask

    task automatic lsu_op(input bit we, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd, output int lat);
        int n0;
        issue_lsu(we, sz, sx, a, wd, n0);
        wait_done(20);
        lat = lsu_ack_cyc - n0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_ctl"}, {30'b0, mem_op, mem_rw}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_data_w"}, mem_data_w, 32'd0);
        chk({tag, "_ack_err"}, {28'b0, ifu_ack, ifu_err, lsu_ack, lsu_err}, 32'd0);
        chk({tag, "_ifu_rdata"}, ifu_rdata, 32'd0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, lat, r0, w0, a0, base_hw, base_acc, mism;
        repeat (2) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        sys_rst = 1'b0;
        step(0);

        lsu_op(1, 2'd2, 0, 32'h8, 32'hDEADBEEF, lat);
        lsu_op(1, 2'd2, 0, 32'h4, 32'h01234567, lat);
        lsu_op(1, 2'd2, 0, 32'h0, 32'h00500593, lat);
        chk("word_store_lat", 32'(lat), 32'd2);

        @(posedge sys_clk); #1; sys_rst = 1'b1;
        @(posedge sys_clk); #1; sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        ifu_addr = 32'h4; ifu_req = 1'b1;
        lsu_we = 1'b0; lsu_size = 2'd2; lsu_sext = 1'b0; lsu_addr = 32'h8; lsu_req = 1'b1;
        n0 = cyc;
        wait_done(30);
        chk("contend_lsu_lat", 32'(lsu_ack_cyc - n0), 32'd2);
        chk("contend_ifu_gap", 32'(ifu_ack_cyc - lsu_ack_cyc), 32'd3);
        chk("contend_lsu_data", lsu_last_rdata, 32'hDEADBEEF);
        chk("contend_ifu_data", ifu_last_rdata, 32'h01234567);

        @(posedge sys_clk); #1;
        ifu_addr = 32'h0; ifu_req = 1'b1; n0 = cyc;
        wait_done(20);
        chk("fetch_lat", 32'(ifu_ack_cyc - n0), 32'd2);
        chk("fetch_data", ifu_last_rdata, 32'h00500593);
        chk("fetch_err", 32'(ifu_last_err), 32'd0);

        lsu_op(1, 2'd2, 0, 32'h10, 32'h11223344, lat);
        r0 = rd_cnt; w0 = wr_cnt;
        lsu_op(1, 2'd0, 0, 32'h11, 32'h5A5A5AAB, lat);
        chk("bstore_lat", 32'(lat), 32'd3);
        chk("bstore_reads", 32'(rd_cnt - r0), 32'd1);
        chk("bstore_writes", 32'(wr_cnt - w0), 32'd1);
        chk("bstore_word", peek(32'h10), 32'h1122AB44);

        lsu_op(1, 2'd2, 0, 32'h10, 32'h80FF0000, lat);
        lsu_op(0, 2'd1, 1, 32'h12, 32'h0, lat);
        chk("hload_lat", 32'(lat), 32'd2);
        chk("hload_sext", lsu_last_rdata, 32'hFFFF80FF);
        lsu_op(0, 2'd1, 0, 32'h12, 32'h0, lat);
        chk("hload_zext", lsu_last_rdata, 32'h000080FF);
        lsu_op(0, 2'd0, 1, 32'h13, 32'h0, lat);
        chk("bload_sext", lsu_last_rdata, 32'hFFFFFF80);

        r0 = rd_cnt + wr_cnt;
        lsu_op(0, 2'd2, 0, 32'h6, 32'h0, lat);
        chk("misalign_err", 32'(lsu_last_err), 32'd1);
        chk("misalign_lat", 32'(lat), 32'd1);
        lsu_op(0, 2'd2, 0, 32'd1022, 32'h0, lat);
        chk("range_err", 32'(lsu_last_err), 32'd1);
        chk("range_lat", 32'(lat), 32'd1);
        lsu_op(0, 2'd3, 0, 32'h10, 32'h0, lat);
        chk("size3_err", 32'(lsu_last_err), 32'd1);
        chk("err_no_mem", 32'(rd_cnt + wr_cnt - r0), 32'd0);
        lsu_op(0, 2'd1, 0, 32'd1022, 32'h0, lat);
        chk("edge_half_ok", 32'(lsu_last_err), 32'd0);
        @(posedge sys_clk); #1;
        ifu_addr = 32'h2; ifu_req = 1'b1;
        wait_done(20);
        chk("fetch_misalign", 32'(ifu_last_err), 32'd1);

        lsu_op(1, 2'd2, 0, 32'h20, 32'hCAFEBABE, lat);
        w0 = wr_cnt; a0 = lsu_acks;
        issue_lsu(1, 2'd1, 0, 32'h22, 32'h00001234, n0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1; lsu_req = 1'b0;
        @(posedge sys_clk); #1;
        check_all_zero("abort");
        sys_rst = 1'b0;
        repeat (6) step(0);
        chk("abort_no_ack", 32'(lsu_acks - a0), 32'd0);
        chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("abort_mem_word", peek(32'h20), 32'hCAFEBABE);

        base_hw  = rd_cnt + wr_cnt;
        base_acc = acc_total;
        repeat (3000) step(1);
        wait_done(100);
        mism = 0;
        for (int i = 0; i < MS; i++) if (phys[i] !== refm[i]) mism++;
        chk("mem_image", 32'(mism), 32'd0);
        chk("mem_access_count", 32'(rd_cnt + wr_cnt - base_hw), 32'(acc_total - base_acc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
